// File: rtl/wddl_key_expand.sv
// On-the-fly AES-128 key schedule in WDDL dual-rail form, one round key per EVAL cycle.
// Define WDDL_PRECHARGE_EN to insert an all-zero PRE cycle between consecutive round keys.

module sbox_dr (
   input  logic [7:0] in_t_i,
   input  logic [7:0] in_f_i,
   output logic [7:0] out_t_o,
   output logic [7:0] out_f_o
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254 via repeated squaring, then the AES affine transform.
   function automatic logic [7:0] sbox_val(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] b;
      sq = a;
      b  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         b  = gmul(b, sq);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [2047:0] gen_tbl();
      logic [2047:0] t;
      t = '0;
      for (int v = 0; v < 256; v++) t[v*8 +: 8] = sbox_val(8'(v));
      return t;
   endfunction

   localparam logic [2047:0] SboxTbl = gen_tbl();

   logic m;

   // Monotone decode-then-OR: both outputs stay 0 while the inputs are precharged.
   always_comb begin
      out_t_o = '0;
      out_f_o = '0;
      m       = 1'b0;
      for (int v = 0; v < 256; v++) begin
         m = 1'b1;
         for (int b = 0; b < 8; b++) m = m & (v[b] ? in_t_i[b] : in_f_i[b]);
         for (int i = 0; i < 8; i++) begin
            if (SboxTbl[v*8 + i]) out_t_o[i] = out_t_o[i] | m;
            else                  out_f_o[i] = out_f_o[i] | m;
         end
      end
   end

endmodule

module wddl_key_expand (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ld_i,
   input  logic [127:0] key_in_i,
   input  logic [127:0] key_in_n_i,
   output logic [31:0]  w0_o,
   output logic [31:0]  w1_o,
   output logic [31:0]  w2_o,
   output logic [31:0]  w3_o,
   output logic [31:0]  w0_n_o,
   output logic [31:0]  w1_n_o,
   output logic [31:0]  w2_n_o,
   output logic [31:0]  w3_n_o,
   output logic         kvalid_o,
   output logic [3:0]   round_o,
   output logic         done_o,
   output logic         rail_err_o
);

   typedef enum logic [1:0] {StIdle, StEval, StPre} st_e;

   st_e          st_q, st_d;
   logic [127:0] kt_q, kt_d, kf_q, kf_d;
   logic [127:0] out_t_q, out_t_d, out_f_q, out_f_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         kvalid_q, kvalid_d, done_q, done_d, rail_err_q, rail_err_d;
   logic         adv;

   logic [31:0]  rot_t, rot_f, sub_t, sub_f, subr_t, subr_f;
   logic [127:0] nk_t, nk_f;

   function automatic logic [31:0] dxor_t(input logic [31:0] at, input logic [31:0] af,
                                          input logic [31:0] bt, input logic [31:0] bf);
      return (at & bf) | (af & bt);
   endfunction

   function automatic logic [31:0] dxor_f(input logic [31:0] at, input logic [31:0] af,
                                          input logic [31:0] bt, input logic [31:0] bf);
      return (at & bt) | (af & bf);
   endfunction

   assign rot_t = {kt_q[23:0], kt_q[31:24]};
   assign rot_f = {kf_q[23:0], kf_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_sbox
      sbox_dr u_sbox (
         .in_t_i  (rot_t[j*8 +: 8]),
         .in_f_i  (rot_f[j*8 +: 8]),
         .out_t_o (sub_t[j*8 +: 8]),
         .out_f_o (sub_f[j*8 +: 8])
      );
   end

   // XOR with the rcon constant is a rail swap on the bits where rcon is set.
   always_comb begin
      subr_t = sub_t;
      subr_f = sub_f;
      for (int i = 0; i < 8; i++) begin
         subr_t[24 + i] = rcon_q[i] ? sub_f[24 + i] : sub_t[24 + i];
         subr_f[24 + i] = rcon_q[i] ? sub_t[24 + i] : sub_f[24 + i];
      end
   end

   always_comb begin
      nk_t = '0;
      nk_f = '0;
      nk_t[127:96] = dxor_t(kt_q[127:96], kf_q[127:96], subr_t, subr_f);
      nk_f[127:96] = dxor_f(kt_q[127:96], kf_q[127:96], subr_t, subr_f);
      nk_t[95:64]  = dxor_t(kt_q[95:64], kf_q[95:64], nk_t[127:96], nk_f[127:96]);
      nk_f[95:64]  = dxor_f(kt_q[95:64], kf_q[95:64], nk_t[127:96], nk_f[127:96]);
      nk_t[63:32]  = dxor_t(kt_q[63:32], kf_q[63:32], nk_t[95:64], nk_f[95:64]);
      nk_f[63:32]  = dxor_f(kt_q[63:32], kf_q[63:32], nk_t[95:64], nk_f[95:64]);
      nk_t[31:0]   = dxor_t(kt_q[31:0], kf_q[31:0], nk_t[63:32], nk_f[63:32]);
      nk_f[31:0]   = dxor_f(kt_q[31:0], kf_q[31:0], nk_t[63:32], nk_f[63:32]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) st_q <= StIdle;
      else       st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      if (ld_i) begin
         st_d = StEval;
      end else begin
         unique case (st_q)
            StEval: begin
               if (round_q == 4'd10) st_d = StIdle;
`ifdef WDDL_PRECHARGE_EN
               else                  st_d = StPre;
`else
               else                  st_d = StEval;
`endif
            end
            StPre:   st_d = StEval;
            default: st_d = StIdle;
         endcase
      end
   end

   always_comb begin
      kt_d       = kt_q;
      kf_d       = kf_q;
      round_d    = round_q;
      rcon_d     = rcon_q;
      out_t_d    = '0;
      out_f_d    = '0;
      kvalid_d   = 1'b0;
      done_d     = 1'b0;
      rail_err_d = rail_err_q;
      adv        = 1'b0;
      if (ld_i) begin
         // The false rail is rebuilt from key_in so a faulty key_in_n cannot break rail pairing.
         kt_d       = key_in_i;
         kf_d       = ~key_in_i;
         out_t_d    = key_in_i;
         out_f_d    = ~key_in_i;
         round_d    = '0;
         rcon_d     = 8'h01;
         kvalid_d   = 1'b1;
         rail_err_d = rail_err_q | ((key_in_i ^ key_in_n_i) != {128{1'b1}});
      end else begin
         unique case (st_q)
            StEval: begin
               if (round_q == 4'd10) round_d = '0;
`ifndef WDDL_PRECHARGE_EN
               else                  adv = 1'b1;
`endif
            end
            StPre:   adv = 1'b1;
            default: round_d = '0;
         endcase
      end
      if (adv) begin
         kt_d     = nk_t;
         kf_d     = nk_f;
         out_t_d  = nk_t;
         out_f_d  = nk_f;
         round_d  = round_q + 4'd1;
         rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
         kvalid_d = 1'b1;
         done_d   = (round_q == 4'd9);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         kt_q       <= '0;
         kf_q       <= '0;
         out_t_q    <= '0;
         out_f_q    <= '0;
         round_q    <= '0;
         rcon_q     <= '0;
         kvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         rail_err_q <= 1'b0;
      end else begin
         kt_q       <= kt_d;
         kf_q       <= kf_d;
         out_t_q    <= out_t_d;
         out_f_q    <= out_f_d;
         round_q    <= round_d;
         rcon_q     <= rcon_d;
         kvalid_q   <= kvalid_d;
         done_q     <= done_d;
         rail_err_q <= rail_err_d;
      end
   end

   assign w0_o       = out_t_q[127:96];
   assign w1_o       = out_t_q[95:64];
   assign w2_o       = out_t_q[63:32];
   assign w3_o       = out_t_q[31:0];
   assign w0_n_o     = out_f_q[127:96];
   assign w1_n_o     = out_f_q[95:64];
   assign w2_n_o     = out_f_q[63:32];
   assign w3_n_o     = out_f_q[31:0];
   assign kvalid_o   = kvalid_q;
   assign round_o    = round_q;
   assign done_o     = done_q;
   assign rail_err_o = rail_err_q;

endmodule

// File: tb/tb_wddl_key_expand.sv
// Directed bench for wddl_key_expand using FIPS-197 key-expansion vectors.
// Timing expectations follow WDDL_PRECHARGE_EN when it is defined for the build.

module tb_wddl_key_expand;

`ifdef WDDL_PRECHARGE_EN
   localparam int Step = 2;
`else
   localparam int Step = 1;
`endif

   localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         rst, ld;
   logic [127:0] key_in, key_in_n;
   logic [31:0]  w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n;
   logic         kvalid, done, rail_err;
   logic [3:0]   round;
   logic [127:0] w, wn;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           c;

   assign w  = {w0, w1, w2, w3};
   assign wn = {w0_n, w1_n, w2_n, w3_n};

   always #5 clk = ~clk;

   wddl_key_expand dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ld_i       (ld),
      .key_in_i   (key_in),
      .key_in_n_i (key_in_n),
      .w0_o       (w0),
      .w1_o       (w1),
      .w2_o       (w2),
      .w3_o       (w3),
      .w0_n_o     (w0_n),
      .w1_n_o     (w1_n),
      .w2_n_o     (w2_n),
      .w3_n_o     (w3_n),
      .kvalid_o   (kvalid),
      .round_o    (round),
      .done_o     (done),
      .rail_err_o (rail_err)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock, then the per-cycle rail/precharge/done invariants.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (kvalid) begin
         check_eq("rail_compl", wn, ~w);
      end else begin
         check_eq("pre_true", w, '0);
         check_eq("pre_false", wn, '0);
      end
      check_eq("done_align", 128'(done), 128'(kvalid && (round == 4'd10)));
   endtask

   task automatic load(input logic [127:0] k, input logic [127:0] kn);
      key_in   = k;
      key_in_n = kn;
      ld       = 1'b1;
      cyc();
      ld       = 1'b0;
   endtask

   task automatic run_to_round(input int r, output int cycles);
      cycles = 0;
      while (!(kvalid && (round == 4'(r))) && (cycles < 40)) begin
         cyc();
         cycles++;
      end
      check_eq("reach_round", 128'(kvalid && (round == 4'(r))), 128'(1));
   endtask

   initial begin
      rst      = 1'b1;
      ld       = 1'b0;
      key_in   = '0;
      key_in_n = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) cyc();
      check_eq("idle_kvalid", 128'(kvalid), 128'(0));
      check_eq("idle_round", 128'(round), 128'(0));
      check_eq("idle_rail_err", 128'(rail_err), 128'(0));

      // FIPS-197 appendix A.1 key
      load(K1, ~K1);
      check_eq("k1_r0", w, K1);
      check_eq("k1_r0_round", 128'(round), 128'(0));
      check_eq("k1_r0_valid", 128'(kvalid), 128'(1));
      run_to_round(1, c);
      check_eq("k1_r1_lat", 128'(c), 128'(Step));
      check_eq("k1_r1", w, K1R1);
      run_to_round(10, c);
      check_eq("k1_r10_lat", 128'(c), 128'(9 * Step));
      check_eq("k1_r10", w, K1R10);
      check_eq("k1_done", 128'(done), 128'(1));
      cyc();
      check_eq("k1_after_valid", 128'(kvalid), 128'(0));
      check_eq("k1_after_round", 128'(round), 128'(0));
      check_eq("k1_rail_err", 128'(rail_err), 128'(0));

      // FIPS-197 appendix C.1 key
      load(K2, ~K2);
      check_eq("k2_r0", w, K2);
      run_to_round(1, c);
      check_eq("k2_r1", w, K2R1);
      run_to_round(10, c);
      check_eq("k2_r10", w, K2R10);
      check_eq("k2_done", 128'(done), 128'(1));
      repeat (2) cyc();
      check_eq("k2_idle_valid", 128'(kvalid), 128'(0));

      // Restart mid-expansion, then restart in the done cycle
      load(K1, ~K1);
      run_to_round(4, c);
      load(K2, ~K2);
      check_eq("rs1_r0", w, K2);
      check_eq("rs1_round", 128'(round), 128'(0));
      run_to_round(1, c);
      check_eq("rs1_r1_lat", 128'(c), 128'(Step));
      check_eq("rs1_r1", w, K2R1);
      run_to_round(10, c);
      check_eq("rs1_r10", w, K2R10);
      load(K1, ~K1);
      check_eq("rs2_r0", w, K1);
      check_eq("rs2_round", 128'(round), 128'(0));
      check_eq("rs2_valid", 128'(kvalid), 128'(1));
      run_to_round(1, c);
      check_eq("rs2_r1", w, K1R1);

      // Non-complementary key: bit 0 of the false rail equals the true rail
      load(K2, ~K2 ^ 128'h1);
      check_eq("re_set", 128'(rail_err), 128'(1));
      check_eq("re_key", w, K2);
      run_to_round(1, c);
      check_eq("re_r1", w, K2R1);
      load(K1, ~K1);
      check_eq("re_sticky", 128'(rail_err), 128'(1));
      cyc();
      cyc();

      // Asynchronous reset mid-expansion
      rst = 1'b1;
      #1;
      check_eq("rst_w", w, '0);
      check_eq("rst_wn", wn, '0);
      check_eq("rst_valid", 128'(kvalid), 128'(0));
      check_eq("rst_round", 128'(round), 128'(0));
      check_eq("rst_rail_err", 128'(rail_err), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) cyc();
      check_eq("post_rst_valid", 128'(kvalid), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wddl_key_expand.md
# wddl_key_expand

On-the-fly AES-128 key schedule in WDDL dual-rail form. It sits directly upstream of the round state register and supplies that register's round-key inputs `w0..w3` / `w0_n..w3_n`. A load starts expansion of a 128-bit cipher key, and one round key is emitted per round (0..10). Whenever no key is valid, both rails are held at the all-zero precharge value.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ld` input 1: start or restart expansion with `key_in`/`key_in_n`; accepted in any state; meant to be asserted in the same cycle as `ld_r` to the state register.
- `key_in` input 128: cipher key, true rail; bits [127:96] are word 0.
- `key_in_n` input 128: cipher key, false rail; expected to equal `~key_in`.
- `w0`, `w1`, `w2`, `w3` output 32 each: current round key words, true rail.
- `w0_n`, `w1_n`, `w2_n`, `w3_n` output 32 each: current round key words, false rail.
- `kvalid` output 1: high when `w*`/`w*_n` carry a valid (evaluate-phase) round key.
- `round` output 4: index of the key on the outputs, 0..10.
- `done` output 1: one-cycle pulse coincident with the round-10 key.
- `rail_err` output 1: sticky flag for a non-complementary key at load.

## Operation
- Reset values:
  - all `w*` = 0 and all `w*_n` = 0 (precharge);
  - `kvalid` = 0, `round` = 0, `done` = 0, `rail_err` = 0;
  - FSM in IDLE.
- FSM states are IDLE and EVAL, plus PRE when the configuration macro is defined.
- IDLE: outputs precharged (both rails 0), `kvalid` = 0, `round` holds 0.
- `ld` high at an edge, in any state:
  - internal key registers load `key_in`;
  - the next cycle is EVAL with `round` = 0 and `w0..w3` = key words 0..3;
  - the restart aborts any expansion in progress.
- Each EVAL→next-EVAL advance computes round r+1 from round r:
  - `w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon[r+1], 24'h0}`;
  - `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`.
- RotWord is a left rotate by one byte.
- SubWord uses four instances of the dual-rail S-box submodule `sbox_dr`.
- rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. rcon is held in an 8-bit register that is doubled in GF(2^8) each round (xtime: shift left, XOR 1b on carry).
- Rail rule in EVAL: `w*_n` == `~w*` bit-exact. The false rail is produced by the dual-rail logic, not by inverting the registered true rail at the output.
- Round 10 in EVAL: `done` = 1 for that cycle; the next state is IDLE unless `ld` is high.
- `ld` in the same cycle as `done`: the restart wins; the next cycle is EVAL round 0 of the new key.
- `rail_err`:
  - set on the cycle after an accepted `ld` if `(key_in ^ key_in_n) != {128{1'b1}}`;
  - cleared only by `rst`;
  - expansion still proceeds using the `key_in` rail.
- `rst` mid-expansion: immediate return to the reset values; no key is emitted afterward until the next `ld`.

## Timing
- Load-to-key latency: round-0 key valid 1 cycle after the `ld` edge.
- Without the macro: round k is valid k+1 cycles after `ld`, keys are back-to-back, and `done` falls on cycle 11.
- With the macro: round k is valid 2k+1 cycles after `ld`, and `done` falls on cycle 21.
- All outputs are registered; no combinational path from any input to any output.
- Transitions into and out of valid keys always pass through the all-zero precharge value, never through a true/false pair.

## Configuration
- `WDDL_PRECHARGE_EN` defined:
  - a PRE cycle is inserted after every EVAL cycle except round 10;
  - in PRE, all `w*` and `w*_n` = 0 and `kvalid` = 0;
  - `round` and the internal key/rcon registers hold;
  - `ld` during PRE restarts normally.
- Not defined: the PRE state does not exist, and EVAL cycles are consecutive.

## Test plan
- Reset, then idle for 5 cycles -> all `w*` and `w*_n` = 0, `kvalid` = 0, `round` = 0, `done` = 0, `rail_err` = 0.
- `ld` with key 2b7e151628aed2a6abf7158809cf4f3c and matching complement -> expected sequence:
  - round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c;
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with `done` = 1;
  - `w*_n` = `~w*` on every valid cycle.
- `ld` with key 000102030405060708090a0b0c0d0e0f -> expected sequence:
  - round 1 = d6aa74fd d2af72fa daa678f1 d6ab76fe;
  - round 10 = 13111d7f e3944a17 f307a78b 4d2b30c5;
  - then IDLE with both rails 0.
- Restart at round 4, with a second `ld` also asserted in the `done` cycle -> each restart produces round 0 of the new key exactly one cycle later; no stale round keys appear.
- `ld` with `key_in_n` bit 0 equal to `key_in` bit 0 -> `rail_err` = 1 the next cycle and stays high through a later clean `ld`; it clears only after `rst`.
- With `WDDL_PRECHARGE_EN` -> odd cycles carry valid keys, even cycles are all-zero on both rails with `kvalid` = 0, and `done` lands on cycle 21.
